// File: rtl/pcie_lane_pkg.sv
// Shared types and constants for the multi-lane serial link.
package pcie_lane_pkg;

   // Link training state as presented on LinkState.
   typedef enum logic [1:0] {
      DETECT   = 2'd0,
      TRAINING = 2'd1,
      L0       = 2'd2
   } link_state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hBC;
   localparam logic [7:0] IDLE_DEFAULT = 8'h7C;

   // LSB index of lane i inside a packed LANES*w bus.
   function automatic int unsigned lane_slice(input int unsigned i, input int unsigned w);
      return i * w;
   endfunction

endpackage

// File: rtl/pcie_lane_rx.sv
// Per-lane RX deserialiser: hunts for SYNC, then frames W-bit words, counts
// training words and forwards data words while the link is in L0.
module pcie_lane_rx
   import pcie_lane_pkg::*;
#(
   parameter int unsigned  W        = 8,
   parameter logic [W-1:0] SYNC     = W'(SYNC_DEFAULT),
   parameter logic [W-1:0] IDLE     = W'(IDLE_DEFAULT),
   parameter int unsigned  TS_COUNT = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         din_i,
   input  logic         in_l0_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic         aligned_o,
   output logic         trained_o
);

   localparam int unsigned CW = $clog2(W);
   localparam int unsigned SW = $clog2(TS_COUNT + 1);

   logic [W-1:0]  shift_q, shift_d;
   logic [CW-1:0] word_cnt_q, word_cnt_d;
   logic [SW-1:0] sync_cnt_q, sync_cnt_d;
   logic          aligned_q, aligned_d;
   logic [W-1:0]  data_q, data_d;
   logic          valid_q, valid_d;

   // Next state: shift in at MSB, hunt for SYNC, classify each completed word.
   always_comb begin
      shift_d    = {din_i, shift_q[W-1:1]};
      word_cnt_d = word_cnt_q;
      sync_cnt_d = sync_cnt_q;
      aligned_d  = aligned_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      if (!aligned_q) begin
         if (shift_q == SYNC) begin
            aligned_d  = 1'b1;
            word_cnt_d = '0;
            sync_cnt_d = SW'(1);
         end
      end else begin
         word_cnt_d = (word_cnt_q == CW'(W - 1)) ? '0 : word_cnt_q + CW'(1);
         if (word_cnt_q == CW'(W - 1)) begin
            if (shift_q == SYNC) begin
               if (sync_cnt_q != SW'(TS_COUNT)) begin
                  sync_cnt_d = sync_cnt_q + SW'(1);
               end
            end else if (shift_q == IDLE) begin
               sync_cnt_d = sync_cnt_q;
            end else if (in_l0_i) begin
               data_d  = shift_q;
               valid_d = 1'b1;
            end else begin
               // A stray word outside L0 means we locked on the wrong boundary.
               aligned_d  = 1'b0;
               sync_cnt_d = '0;
            end
         end
      end
   end

   // Lane state register; clear_i drops everything when the link falls to DETECT.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         shift_q    <= '0;
         word_cnt_q <= '0;
         sync_cnt_q <= '0;
         aligned_q  <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         word_cnt_q <= word_cnt_d;
         sync_cnt_q <= sync_cnt_d;
         aligned_q  <= aligned_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign aligned_o = aligned_q;
   assign trained_o = (sync_cnt_q == SW'(TS_COUNT));

endmodule

// File: rtl/pcie_lane_link.sv
// N-lane serial link: shared TX serialiser, per-lane RX deserialisers and the
// DETECT/TRAINING/L0 training FSM. Optional internal loopback is compiled in
// with PCIE_LANE_LOOPBACK_EN.
module pcie_lane_link
   import pcie_lane_pkg::*;
#(
   parameter int unsigned LANES         = 16,
   parameter int unsigned W             = 8,
   parameter logic [7:0]  SYNC          = SYNC_DEFAULT,
   parameter logic [7:0]  IDLE          = IDLE_DEFAULT,
   parameter int unsigned TS_COUNT      = 8,
   parameter int unsigned TRAIN_TIMEOUT = 4096
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Stable,
`ifdef PCIE_LANE_LOOPBACK_EN
   input  logic                 Loopback,
`endif
   input  logic [LANES-1:0]     DataIn,
   output logic [LANES-1:0]     DataOut,
   input  logic [LANES*W-1:0]   TxData,
   input  logic                 TxValid,
   output logic                 TxReady,
   output logic [LANES*W-1:0]   RxData,
   output logic [LANES-1:0]     RxValid,
   output logic [LANES-1:0]     LaneAligned,
   output logic                 LinkUp,
   output logic [1:0]           LinkState
);

   localparam int unsigned  BW     = $clog2(W);
   localparam int unsigned  TW     = $clog2(TRAIN_TIMEOUT);
   localparam logic [W-1:0] SYNC_W = W'(SYNC);
   localparam logic [W-1:0] IDLE_W = W'(IDLE);

   link_state_t        state_q, state_d;
   logic [BW-1:0]      tx_bit_q, tx_bit_d;
   logic [TW-1:0]      timeout_q, timeout_d;
   logic [LANES*W-1:0] tx_shift_q, tx_shift_d;
   logic [LANES-1:0]   tx_serial, rx_serial, lane_trained;
   logic               word_end, lane_clear;

   assign word_end   = (tx_bit_q == BW'(W - 1));
   assign lane_clear = (state_d == DETECT);

   // Training FSM next state; losing Stable overrides every other transition.
   always_comb begin
      state_d   = state_q;
      timeout_d = timeout_q;
      unique case (state_q)
         DETECT: begin
            if (Stable) begin
               state_d   = TRAINING;
               timeout_d = '0;
            end
         end
         TRAINING: begin
            if (&lane_trained) begin
               state_d = L0;
            end else if (timeout_q == TW'(TRAIN_TIMEOUT - 1)) begin
               state_d = DETECT;
            end else begin
               timeout_d = timeout_q + TW'(1);
            end
         end
         L0:      state_d = L0;
         default: state_d = DETECT;
      endcase
      if (!Stable) begin
         state_d = DETECT;
      end
   end

   // TX serialiser next state: shift each lane right, reload on word boundaries.
   always_comb begin
      tx_bit_d = tx_bit_q + BW'(1);
      for (int i = 0; i < LANES; i++) begin
         tx_shift_d[lane_slice(i, W) +: W] = {1'b0, tx_shift_q[lane_slice(i, W) + 1 +: W - 1]};
      end
      if (state_d == DETECT) begin
         tx_bit_d   = '0;
         tx_shift_d = '0;
      end else if (state_q == DETECT) begin
         // Leaving DETECT starts the first SYNC word immediately.
         tx_bit_d   = '0;
         tx_shift_d = {LANES{SYNC_W}};
      end else if (word_end) begin
         tx_bit_d = '0;
         for (int i = 0; i < LANES; i++) begin
            if (state_q == L0) begin
               tx_shift_d[lane_slice(i, W) +: W] = TxValid ? TxData[lane_slice(i, W) +: W] : IDLE_W;
            end else begin
               tx_shift_d[lane_slice(i, W) +: W] = SYNC_W;
            end
         end
      end
   end

   // State, bit counter, timeout and TX shift registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= DETECT;
         tx_bit_q   <= '0;
         timeout_q  <= '0;
         tx_shift_q <= '0;
      end else begin
         state_q    <= state_d;
         tx_bit_q   <= tx_bit_d;
         timeout_q  <= timeout_d;
         tx_shift_q <= tx_shift_d;
      end
   end

`ifdef PCIE_LANE_LOOPBACK_EN
   assign rx_serial = Loopback ? tx_serial : DataIn;
   assign DataOut   = Loopback ? '0 : tx_serial;
`else
   assign rx_serial = DataIn;
   assign DataOut   = tx_serial;
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign tx_serial[i] = tx_shift_q[lane_slice(i, W)];

      pcie_lane_rx #(
         .W        (W),
         .SYNC     (SYNC_W),
         .IDLE     (IDLE_W),
         .TS_COUNT (TS_COUNT)
      ) u_rx (
         .clk_i     (Clock),
         .rst_i     (Reset),
         .clear_i   (lane_clear),
         .din_i     (rx_serial[i]),
         .in_l0_i   (state_q == L0),
         .data_o    (RxData[i*W +: W]),
         .valid_o   (RxValid[i]),
         .aligned_o (LaneAligned[i]),
         .trained_o (lane_trained[i])
      );
   end

   assign TxReady   = (state_q == L0) && word_end;
   assign LinkUp    = (state_q == L0);
   assign LinkState = state_q;

endmodule
